sram_port0_ctrl: RTL and testbench

SRAM_PORT0_CTRL -- requirements
Module: sram_port0_ctrl

---
 rtl/sram_port0_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_port0_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_port0_ctrl
// Description : Valid/ready front end for port 0 of a single-port (1RW) SRAM
//               macro. Writes issue at one per cycle. Reads take two cycles
//               from accept to response and block new requests until the
//               response is consumed. All SRAM-facing pins are registered.
//               Optional macro SRAM_PORT0_CTRL_STATS_EN adds 16-bit read and
//               write issue counters (rd_count / wr_count).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // read response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // SRAM port 0
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  // status
  output logic                  busy
`ifdef SRAM_PORT0_CTRL_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_ISSUE = 2'd1;
  localparam logic [1:0] ST_RD_WAIT  = 2'd2;
  localparam logic [1:0] ST_RSP      = 2'd3;

  logic [1:0] state;
  logic       req_fire;
  logic       rsp_fire;

  // Only IDLE accepts requests; a read holds the port until its response drains.
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Control FSM: writes stay in IDLE, reads walk issue -> wait -> response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (req_fire && !req_we) state <= ST_RD_ISSUE;
        ST_RD_ISSUE: state <= ST_RD_WAIT;
        ST_RD_WAIT:  state <= ST_RSP;
        ST_RSP:      if (rsp_fire) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Response register: capture SRAM data once, hold it until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (state == ST_RD_WAIT) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= sram_dout0;
    end else if (state == ST_RSP && rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // SRAM pin registers: one-cycle strobe per accepted request, idle otherwise.
  // Address and write data are held between accesses to avoid needless toggling;
  // a read leaves din untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      if (req_fire) begin
        sram_csb0  <= 1'b0;
        sram_addr0 <= req_addr;
        if (req_we) begin
          sram_web0   <= 1'b0;
          sram_wmask0 <= req_wmask;
          sram_din0   <= req_wdata;
        end
      end
    end
  end

`ifdef SRAM_PORT0_CTRL_STATS_EN
  // Issue counters; a request counts at its accept edge and wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (req_fire) begin
      if (req_we) wr_count <= wr_count + 16'd1;
      else        rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_port0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port0_ctrl
// Description : Self-checking bench for sram_port0_ctrl. Contains a behavioural
//               1RW SRAM (samples on posedge, acts on the following negedge)
//               and a transaction-level reference model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port0_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [NW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0, sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;
  logic          busy;
`ifdef SRAM_PORT0_CTRL_STATS_EN
  logic [15:0]   rd_count, wr_count;
`endif

  always #5 clk = ~clk;

  sram_port0_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .busy(busy)
`ifdef SRAM_PORT0_CTRL_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  // ---------------- behavioural SRAM ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic          s_en = 1'b0;
  logic          s_we = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_din = '0;
  logic [NW-1:0] s_mask = '0;

  always @(posedge clk) begin
    s_en   <= !sram_csb0;
    s_we   <= !sram_web0;
    s_addr <= sram_addr0;
    s_din  <= sram_din0;
    s_mask <= sram_wmask0;
  end

  always @(negedge clk) begin
    if (s_en) begin
      if (s_we) begin
        for (int b = 0; b < NW; b++)
          if (s_mask[b]) sram_mem[s_addr][8*b +: 8] = s_din[8*b +: 8];
      end else begin
        sram_dout0 = sram_mem[s_addr];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          m_out;       // a read is accepted and not yet consumed
  int            m_age;       // clock edges since that read was accepted
  logic [DW-1:0] m_pend, m_rdata;
  logic          m_csb, m_web;
  logic [NW-1:0] m_mask;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [15:0]   m_rdc, m_wrc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 1'b0; m_age = 0; m_pend = '0; m_rdata = '0;
    m_csb = 1'b1; m_web = 1'b1; m_mask = '0; m_addr = '0; m_din = '0;
    m_rdc = 16'd0; m_wrc = 16'd0;
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_csb0",      32'(sram_csb0), 32'd1);
    check("rst_web0",      32'(sram_web0), 32'd1);
    check("rst_wmask0",    32'(sram_wmask0), 32'd0);
    check("rst_addr0",     32'(sram_addr0), 32'd0);
    check("rst_din0",      sram_din0, 32'd0);
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input logic v, input logic we, input logic [NW-1:0] mk,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    logic acc, hs, exp_v;
    req_valid = v; req_we = we; req_wmask = mk; req_addr = a; req_wdata = d;
    rsp_ready = rr;
    @(negedge clk);
    exp_v = m_out && (m_age >= 2);
    check("req_ready", 32'(req_ready), 32'(!m_out));
    check("busy",      32'(busy), 32'(m_out));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    check("rsp_rdata", rsp_rdata, m_rdata);
    check("csb0",      32'(sram_csb0), 32'(m_csb));
    check("web0",      32'(sram_web0), 32'(m_web));
    check("wmask0",    32'(sram_wmask0), 32'(m_mask));
    check("addr0",     32'(sram_addr0), 32'(m_addr));
    check("din0",      sram_din0, m_din);
`ifdef SRAM_PORT0_CTRL_STATS_EN
    check("rd_count",  32'(rd_count), 32'(m_rdc));
    check("wr_count",  32'(wr_count), 32'(m_wrc));
`endif
    acc = v && !m_out;
    hs  = exp_v && rr;
    @(posedge clk);
    m_csb = 1'b1; m_web = 1'b1; m_mask = '0;
    if (hs) begin
      m_out = 1'b0;
    end else if (m_out) begin
      m_age++;
      if (m_age == 2) m_rdata = m_pend;
    end
    if (acc) begin
      m_csb  = 1'b0;
      m_addr = a;
      if (we) begin
        m_web  = 1'b0;
        m_mask = mk;
        m_din  = d;
        for (int b = 0; b < NW; b++)
          if (mk[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        m_wrc = m_wrc + 16'd1;
      end else begin
        m_out  = 1'b1;
        m_age  = 0;
        m_pend = ref_mem[a];
        m_rdc  = m_rdc + 16'd1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[i]  = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    sram_dout0 = '0;
    req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // full write then read back, and a single-lane merge
    step(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 4'h2, 8'h10, 32'h11223344, 1'b1);
    step(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b1);
    idle(3, 1'b1);
    check("merge_0x10", m_rdata, 32'hDEAD33EF);

    // back-to-back burst, then read each back
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'hF, 8'(i), 32'hC0DE_0000 + 32'(i), 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 4'h0, 8'(i), 32'h0, 1'b1);
      idle(3, 1'b1);
    end

    // zero-mask write still strobes the port but changes nothing
    step(1'b1, 1'b1, 4'h0, 8'h02, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 1'b0, 4'h0, 8'h02, 32'h0, 1'b1);
    idle(3, 1'b1);

    // response back-pressure while new requests knock
    step(1'b1, 1'b0, 4'h0, 8'h01, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 4'hF, 8'h05, 32'h5555_AAAA, 1'b0);
    idle(2, 1'b1);

    // reset asserted while the read sits in RD_WAIT
    step(1'b1, 1'b0, 4'h0, 8'h03, 32'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    #3 rst_n = 1'b0;
    #1 check_reset_values();
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    idle(4, 1'b1);
    step(1'b1, 1'b1, 4'hF, 8'h20, 32'h1234_5678, 1'b1);
    step(1'b1, 1'b0, 4'h0, 8'h20, 32'h0, 1'b1);
    idle(3, 1'b1);

    // randomized traffic over a narrow address window to force collisions
    for (int i = 0; i < 600; i++) begin
      logic [NW-1:0] mk;
      mk = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom);
      step(($urandom % 10) < 7, 1'($urandom), mk, 8'($urandom % 16), $urandom,
           ($urandom % 3) != 0);
    end
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
